// File: rtl/instr_encoder.sv
// instr_encoder: two-stage RV32I instruction packer with immediate range checking
// and a wrapping word-address counter.
`default_nettype none

module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  input  logic        addr_clear,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err
);

  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (DEPTH - 1));
  localparam logic signed [31:0] IS_MIN = -32'sd2048;
  localparam logic signed [31:0] IS_MAX = 32'sd2047;
  localparam logic signed [31:0] B_MIN  = -32'sd4096;
  localparam logic signed [31:0] B_MAX  = 32'sd4094;
  localparam logic signed [31:0] J_MIN  = -32'sd1048576;
  localparam logic signed [31:0] J_MAX  = 32'sd1048574;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        s1_valid;
  logic [2:0]  s1_fmt;
  logic [6:0]  s1_opcode;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [2:0]  s1_funct3;
  logic [6:0]  s1_funct7;
  logic [31:0] s1_imm;
  logic        s1_err;
  logic [31:0] addr_cnt;

  logic        range_err;
  logic [31:0] word;
  logic        s2_load;
  logic        accept;

  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_load;
  assign accept   = in_valid && in_ready;

  // Illegal formats are flagged here so the error travels with the word.
  always_comb begin
    range_err = 1'b0;
    case (fmt)
      3'd0:       range_err = 1'b0;
      3'd1, 3'd2: range_err = ($signed(imm) < IS_MIN) || ($signed(imm) > IS_MAX);
      3'd3:       range_err = ($signed(imm) < B_MIN) || ($signed(imm) > B_MAX) || imm[0];
      3'd4:       range_err = |imm[11:0];
      3'd5:       range_err = ($signed(imm) < J_MIN) || ($signed(imm) > J_MAX) || imm[0];
      default:    range_err = 1'b1;
    endcase
  end

  always_comb begin
    word = NOP;
    case (s1_fmt)
      3'd0: word = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
      3'd1: word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
      3'd2: word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
      3'd3: word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                    s1_imm[4:1], s1_imm[11], s1_opcode};
      3'd4: word = {s1_imm[31:12], s1_rd, s1_opcode};
      3'd5: word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                    s1_rd, s1_opcode};
      default: word = NOP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_fmt    <= 3'd0;
      s1_opcode <= 7'd0;
      s1_rd     <= 5'd0;
      s1_rs1    <= 5'd0;
      s1_rs2    <= 5'd0;
      s1_funct3 <= 3'd0;
      s1_funct7 <= 7'd0;
      s1_imm    <= 32'd0;
      s1_err    <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid  <= 1'b1;
        s1_fmt    <= fmt;
        s1_opcode <= opcode;
        s1_rd     <= rd;
        s1_rs1    <= rs1;
        s1_rs2    <= rs2;
        s1_funct3 <= funct3;
        s1_funct7 <= funct7;
        s1_imm    <= imm;
        s1_err    <= range_err;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= 32'd0;
      out_addr  <= BASE_ADDR;
      out_err   <= 1'b0;
    end else begin
      if (s2_load) begin
        out_valid <= 1'b1;
        out_instr <= word;
        out_addr  <= addr_cnt;
        out_err   <= s1_err;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // A clear coinciding with a load still hands the old address to that word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt <= BASE_ADDR;
    end else if (s2_load) begin
      if (addr_clear || addr_cnt == LAST_ADDR) begin
        addr_cnt <= BASE_ADDR;
      end else begin
        addr_cnt <= addr_cnt + 32'd4;
      end
    end else if (addr_clear) begin
      addr_cnt <= BASE_ADDR;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors with hand-computed encodings and addresses.
`default_nettype none

module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  fmt = 3'd0;
  logic [6:0]  opcode = 7'd0;
  logic [4:0]  rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [6:0]  funct7 = 7'd0;
  logic [31:0] imm = 32'd0;
  logic        addr_clear = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   accepted = 0;

  instr_encoder #(.BASE_ADDR(32'h0000_0000), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .addr_clear(addr_clear),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  // Scoreboard: a word is consumed at the posedge following a negedge
  // where out_valid and out_ready are both high.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_word", out_instr, 32'hxxxx_xxxx);
      end else begin
        check("instr", out_instr, exp_q[0].instr);
        check("addr", out_addr, exp_q[0].addr);
        check("err", {31'd0, out_err}, {31'd0, exp_q[0].err});
        void'(exp_q.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  // with in_valid still high so calls can run back to back.
  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                      input logic [4:0] a, input logic [4:0] b, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] im,
                      input logic [31:0] e_instr, input logic [31:0] e_addr, input logic e_err);
    bit ok = 1'b0;
    exp_t e;
    e.instr = e_instr; e.addr = e_addr; e.err = e_err;
    exp_q.push_back(e);
    fmt = f; opcode = op; rd = d; rs1 = a; rs2 = b; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) begin
      check("in_ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      accepted++;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk);
    @(posedge clk);
    #1;
    check("drain", exp_q.size(), 32'd0);
  endtask

  task automatic addi(input logic [31:0] im, input logic [31:0] e_addr);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, im, {im[11:0], 20'h00093}, e_addr, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    #3;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_addr", out_addr, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("clean_release", {31'd0, out_valid}, 32'd0);

    // Basic encodes and latency, addresses wrap every 4 words
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 32'h0, 1'b0);
    idle();
    check("latency_early", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("latency_2", {31'd0, out_valid}, 32'd1);
    send(3'd2, 7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0021_A423, 32'h4, 1'b0);
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4, 32'hFE20_8EE3, 32'h8, 1'b0);
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'h0020_81B3, 32'hC, 1'b0);
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 32'h0, 1'b0);
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'h1234_52B7, 32'h4, 1'b1);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0010_00EF, 32'h8, 1'b0);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000, 32'h8000_00EF, 32'hC, 1'b1);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h8000_0093, 32'h0, 1'b1);
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd6, 32'h0020_8363, 32'h4, 1'b0);
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd5, 32'h0020_8263, 32'h8, 1'b1);
    send(3'd7, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h0000_0013, 32'hC, 1'b1);
    idle();
    drain();

    // Backpressure: four back-to-back inputs against a 4-cycle stall
    do_reset();
    out_ready = 1'b0;
    base = accepted;
    fork
      begin
        addi(32'd1, 32'h0);
        addi(32'd2, 32'h4);
        addi(32'd3, 32'h8);
        addi(32'd4, 32'hC);
        idle();
      end
      begin
        repeat (2) @(posedge clk);
        repeat (3) begin
          @(negedge clk);
          check("stall_valid", {31'd0, out_valid}, 32'd1);
          check("stall_instr", out_instr, 32'h0010_0093);
          check("stall_addr", out_addr, 32'h0);
        end
        check("stall_accepts", accepted - base, 32'd2);
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Wrap with addr_clear on the third load
    do_reset();
    base = accepted;
    fork
      begin
        addi(32'd1, 32'h0);
        addi(32'd2, 32'h4);
        addi(32'd3, 32'h8);
        addi(32'd4, 32'h0);
        addi(32'd5, 32'h4);
        addi(32'd6, 32'h8);
        idle();
      end
      begin
        wait (accepted == base + 3);
        addr_clear = 1'b1;
        @(posedge clk);
        #1 addr_clear = 1'b0;
      end
    join
    drain();

    // Plain wrap without clear
    do_reset();
    addi(32'd7, 32'h0);
    addi(32'd8, 32'h4);
    addi(32'd9, 32'h8);
    addi(32'd10, 32'hC);
    addi(32'd11, 32'h0);
    addi(32'd12, 32'h4);
    idle();
    drain();

    // Reset with both stages full
    out_ready = 1'b0;
    addi(32'd1, 32'h8);
    addi(32'd2, 32'hC);
    idle();
    check("full_before_rst", {31'd0, out_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_addr", out_addr, 32'h0);
    check("midrst_out_instr", out_instr, 32'h0);
    exp_q.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    addi(32'd7, 32'h0);
    idle();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
